// File: rtl/pe_pkg.sv
// pe_pkg: shared PE mode encodings, format field widths, biases and beat layout
package pe_pkg;
  localparam int LANES = 4;
  localparam int MAN_W = 53;
  localparam int EXP_W = 13;
  localparam logic [1:0] MODE_FP16 = 2'b00;
  localparam logic [1:0] MODE_FP32 = 2'b01;
  localparam logic [1:0] MODE_FP64 = 2'b10;
  localparam logic [1:0] MODE_IDLE = 2'b11;
  localparam int FP16_EW = 5;
  localparam int FP16_FW = 10;
  localparam int FP32_EW = 8;
  localparam int FP32_FW = 23;
  localparam int FP64_EW = 11;
  localparam int FP64_FW = 52;
  localparam int FP16_BIAS = 15;
  localparam int FP32_BIAS = 127;
  localparam int FP64_BIAS = 1023;
  typedef struct packed {
    logic sign;
    logic [FP64_EW-1:0] exp;
    logic [MAN_W-1:0] man;
    logic zero;
    logic inf;
    logic nan;
  } fld_t;
  typedef struct packed {
    logic [1:0] mode;
    logic [LANES-1:0] sign;
    logic [LANES*MAN_W-1:0] man_a;
    logic [LANES*MAN_W-1:0] man_b;
    logic [LANES*EXP_W-1:0] exp_sum;
    logic [LANES-1:0] zero;
    logic nan;
    logic inf;
  } beat_t;
  function automatic beat_t beat_rst();
    beat_t r;
    r = '0;
    r.mode = MODE_IDLE;
    r.zero = '1;
    return r;
  endfunction
endpackage

// File: rtl/fp_field_decode.sv
// fp_field_decode: splits one IEEE operand into sign/exponent/mantissa and special flags
module fp_field_decode #(
  parameter int EW = 5,
  parameter int FW = 10
) (
  input  logic [EW+FW:0] x,
  output logic           sign,
  output logic [EW-1:0]  exp,
  output logic [FW:0]    man,
  output logic           is_zero,
  output logic           is_inf,
  output logic           is_nan
);
  logic [EW-1:0] e;
  logic [FW-1:0] f;
  assign {sign, e, f} = x;
  assign is_zero = e == '0 && f == '0;
  assign is_inf = &e && f == '0;
  assign is_nan = &e && f != '0;
  // subnormals share the exponent of the smallest normal
  assign exp = (e == '0 && !is_zero) ? EW'(1) : e;
  assign man = {|e, f};
endmodule

// File: rtl/pip0_unpacking.sv
// pip0_unpacking: per-lane FP operand decode, product exponents and max, 2-stage valid/ready
module pip0_unpacking
  import pe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid,
  output logic                   o_ready_in,
  input  logic [1:0]             i_mode_sel,
  input  logic [63:0]            i_a,
  input  logic [63:0]            i_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [1:0]             o_mode_sel,
  output logic [LANES-1:0]       o_sign,
  output logic [LANES*MAN_W-1:0] o_man_a,
  output logic [LANES*MAN_W-1:0] o_man_b,
  output logic [LANES*EXP_W-1:0] o_exp_sum,
  output logic [EXP_W-1:0]       o_exp_max,
  output logic [LANES-1:0]       o_zero,
  output logic                   o_nan,
  output logic                   o_inf
);
  logic [63:0] opnd [2];
  fld_t d16 [2][LANES];
  fld_t d32 [2][2];
  fld_t d64 [2];
  assign opnd[0] = i_a;
  assign opnd[1] = i_b;
  for (genvar o = 0; o < 2; o++) begin : g_op
    for (genvar k = 0; k < LANES; k++) begin : g_h
      logic s, z, fi, fn;
      logic [FP16_EW-1:0] e;
      logic [FP16_FW:0] m;
      fp_field_decode #(.EW(FP16_EW), .FW(FP16_FW)) u_dec (
        .x(opnd[o][16*k +: 16]), .sign(s), .exp(e), .man(m), .is_zero(z), .is_inf(fi), .is_nan(fn)
      );
      assign d16[o][k] = '{s, FP64_EW'(e), MAN_W'(m), z, fi, fn};
    end
    for (genvar k = 0; k < 2; k++) begin : g_s
      logic s, z, fi, fn;
      logic [FP32_EW-1:0] e;
      logic [FP32_FW:0] m;
      fp_field_decode #(.EW(FP32_EW), .FW(FP32_FW)) u_dec (
        .x(opnd[o][32*k +: 32]), .sign(s), .exp(e), .man(m), .is_zero(z), .is_inf(fi), .is_nan(fn)
      );
      assign d32[o][k] = '{s, FP64_EW'(e), MAN_W'(m), z, fi, fn};
    end
    begin : g_d
      logic s, z, fi, fn;
      logic [FP64_EW-1:0] e;
      logic [FP64_FW:0] m;
      fp_field_decode #(.EW(FP64_EW), .FW(FP64_FW)) u_dec (
        .x(opnd[o]), .sign(s), .exp(e), .man(m), .is_zero(z), .is_inf(fi), .is_nan(fn)
      );
      assign d64[o] = '{s, e, m, z, fi, fn};
    end
  end
  logic [LANES-1:0] l_sign, l_zero, l_nan, l_inf;
  logic [LANES*MAN_W-1:0] l_man_a, l_man_b;
  logic [LANES*EXP_W-1:0] l_exp;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic act;
    fld_t a, b;
    assign act = i_mode_sel == MODE_FP16 || (k < 2 && i_mode_sel == MODE_FP32) || (k == 0 && i_mode_sel == MODE_FP64);
    assign a = !act ? '0 : i_mode_sel == MODE_FP16 ? d16[0][k] : i_mode_sel == MODE_FP32 ? d32[0][k%2] : d64[0];
    assign b = !act ? '0 : i_mode_sel == MODE_FP16 ? d16[1][k] : i_mode_sel == MODE_FP32 ? d32[1][k%2] : d64[1];
    assign l_sign[k] = a.sign ^ b.sign;
    assign l_zero[k] = !act || a.zero || b.zero;
    assign l_nan[k] = act && (a.nan || b.nan || (a.inf && b.zero) || (a.zero && b.inf));
    assign l_inf[k] = (a.inf || b.inf) && !l_nan[k];
    assign l_man_a[k*MAN_W +: MAN_W] = a.man;
    assign l_man_b[k*MAN_W +: MAN_W] = b.man;
    assign l_exp[k*EXP_W +: EXP_W] = l_zero[k] ? '0 : EXP_W'(a.exp) + EXP_W'(b.exp);
  end
  beat_t nb, s1, s2;
  logic s1_valid, s2_rdy, take;
  logic [EXP_W-1:0] mx;
  assign nb = '{i_mode_sel, l_sign, l_man_a, l_man_b, l_exp, l_zero, |l_nan, |l_inf && !(|l_nan)};
  always_comb begin
    mx = '0;
    for (int k = 0; k < LANES; k++)
      mx = (!s1.zero[k] && s1.exp_sum[k*EXP_W +: EXP_W] > mx) ? s1.exp_sum[k*EXP_W +: EXP_W] : mx;
  end
  assign s2_rdy = !o_valid || i_ready;
  assign o_ready_in = !s1_valid || s2_rdy;
  // idle beats complete the handshake but never occupy S1
  assign take = i_valid && i_mode_sel != MODE_IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1 <= beat_rst();
      o_valid <= 1'b0;
      s2 <= beat_rst();
      o_exp_max <= '0;
    end else begin
      if (o_ready_in) s1_valid <= take;
      if (o_ready_in && take) s1 <= nb;
      if (s2_rdy) o_valid <= s1_valid;
      if (s2_rdy && s1_valid) begin
        s2 <= s1;
        o_exp_max <= mx;
      end
    end
  assign o_mode_sel = s2.mode;
  assign o_sign = s2.sign;
  assign o_man_a = s2.man_a;
  assign o_man_b = s2.man_b;
  assign o_exp_sum = s2.exp_sum;
  assign o_zero = s2.zero;
  assign o_nan = s2.nan;
  assign o_inf = s2.inf;
endmodule

// File: tb/tb_pip0_unpacking.sv
// tb_pip0_unpacking: directed + random scoreboard bench for pip0_unpacking
module tb_pip0_unpacking;
  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] sign;
    logic [211:0] man_a;
    logic [211:0] man_b;
    logic [51:0] exp_sum;
    logic [12:0] exp_max;
    logic [3:0] zero;
    logic nan;
    logic inf;
  } tb_out_t;
  logic clk = 0, rstn = 0, i_valid = 0, i_ready = 1;
  logic [1:0] i_mode_sel = 2'b11;
  logic [63:0] i_a = '0, i_b = '0;
  logic o_ready_in, o_valid, o_nan, o_inf;
  logic [1:0] o_mode_sel;
  logic [3:0] o_sign, o_zero;
  logic [211:0] o_man_a, o_man_b;
  logic [51:0] o_exp_sum;
  logic [12:0] o_exp_max;
  int checks = 0, errors = 0, nout = 0;
  tb_out_t sbv[$];
  tb_out_t last, snap, rx;
  always #5 clk = ~clk;
  pip0_unpacking dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready_in(o_ready_in), .i_mode_sel(i_mode_sel),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready), .o_mode_sel(o_mode_sel),
    .o_sign(o_sign), .o_man_a(o_man_a), .o_man_b(o_man_b), .o_exp_sum(o_exp_sum),
    .o_exp_max(o_exp_max), .o_zero(o_zero), .o_nan(o_nan), .o_inf(o_inf)
  );
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic tb_out_t cap();
    tb_out_t r;
    r.mode = o_mode_sel; r.sign = o_sign; r.man_a = o_man_a; r.man_b = o_man_b;
    r.exp_sum = o_exp_sum; r.exp_max = o_exp_max; r.zero = o_zero; r.nan = o_nan; r.inf = o_inf;
    return r;
  endfunction
  function automatic void dec(input logic [63:0] x, input int ew, input int fw, output logic s,
                              output int e, output logic [52:0] mn, output logic z, output logic inf, output logic nan);
    logic [63:0] f, ef, emax;
    emax = (64'd1 << ew) - 1;
    f = x & ((64'd1 << fw) - 1);
    ef = (x >> fw) & emax;
    s = x[ew+fw];
    z = ef == 0 && f == 0;
    inf = ef == emax && f == 0;
    nan = ef == emax && f != 0;
    e = ef == 0 ? (z ? 0 : 1) : int'(ef);
    mn = 53'(f) | (ef != 0 ? (53'd1 << fw) : 53'd0);
  endfunction
  function automatic tb_out_t model(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    tb_out_t r;
    int n, ew, fw, ea, eb;
    logic sa, sb, za, zb, ia, ib, na, nb, lz, ln;
    logic [52:0] ma, mb;
    logic [12:0] es;
    r = '0; r.mode = m; r.zero = '1;
    n = m == 2'b00 ? 4 : m == 2'b01 ? 2 : 1;
    ew = m == 2'b00 ? 5 : m == 2'b01 ? 8 : 11;
    fw = m == 2'b00 ? 10 : m == 2'b01 ? 23 : 52;
    for (int k = 0; k < n; k++) begin
      dec(a >> ((1 + ew + fw) * k), ew, fw, sa, ea, ma, za, ia, na);
      dec(b >> ((1 + ew + fw) * k), ew, fw, sb, eb, mb, zb, ib, nb);
      lz = za || zb;
      ln = na || nb || (ia && zb) || (za && ib);
      es = lz ? 13'd0 : 13'(ea + eb);
      r.sign[k] = sa ^ sb; r.zero[k] = lz;
      r.man_a[k*53 +: 53] = ma; r.man_b[k*53 +: 53] = mb; r.exp_sum[k*13 +: 13] = es;
      if (ln) r.nan = 1'b1;
      if ((ia || ib) && !ln) r.inf = 1'b1;
      if (!lz && es > r.exp_max) r.exp_max = es;
    end
    if (r.nan) r.inf = 1'b0;
    return r;
  endfunction
  task automatic cyc(output bit acc);
    #1;
    acc = i_valid && o_ready_in;
    if (o_valid && i_ready) begin
      last = cap();
      nout++;
      chk("sb_nonempty", sbv.size() != 0, 1);
      if (sbv.size() != 0) chk("beat", last, sbv.pop_front());
    end
    if (acc && i_mode_sel != 2'b11) sbv.push_back(model(i_mode_sel, i_a, i_b));
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
    bit acc;
    int n = 0;
    i_valid = 1; i_mode_sel = m; i_a = a; i_b = b;
    do begin cyc(acc); n++; end while (!acc && n < 20);
    chk("send_acc", acc, 1);
    i_valid = 0;
  endtask
  task automatic drain();
    bit acc;
    int n = 0;
    i_valid = 0;
    while (sbv.size() != 0 && n < 50) begin cyc(acc); n++; end
    chk("drain_empty", sbv.size(), 0);
  endtask
  initial begin
    bit acc;
    int n0;
    repeat (3) @(posedge clk);
    #1;
    rx = '0; rx.mode = 2'b11; rx.zero = '1;
    chk("rst_valid", o_valid, 0);
    chk("rst_out", cap(), rx);
    rstn = 1;
    #1;
    chk("rst_ready", o_ready_in, 1);
    // FP16 1.0 x 2.0 in every lane, latency 2
    send(2'b00, 64'h3C00_3C00_3C00_3C00, 64'h4000_4000_4000_4000);
    chk("lat_s1", o_valid, 0);
    cyc(acc);
    chk("lat_s2", o_valid, 1);
    drain();
    chk("fp16_exp_sum", last.exp_sum, {4{13'd31}});
    chk("fp16_exp_max", last.exp_max, 13'd31);
    chk("fp16_man_a", last.man_a, {4{53'h400}});
    chk("fp16_man_b", last.man_b, {4{53'h400}});
    chk("fp16_sign", last.sign, 4'b0000);
    // FP32 negative subnormal x 1.0, zero lane, inactive lanes
    send(2'b01, {32'h0000_0000, 32'h8000_0001}, {32'h3F80_0000, 32'h3F80_0000});
    drain();
    chk("fp32_sign", last.sign, 4'b0001);
    chk("fp32_zero", last.zero, 4'b1110);
    chk("fp32_man_a0", last.man_a[52:0], 53'd1);
    chk("fp32_exp0", last.exp_sum[12:0], 13'd128);
    chk("fp32_exp_max", last.exp_max, 13'd128);
    // FP64 specials
    send(2'b10, 64'h7FF0_0000_0000_0000, 64'h0);
    drain();
    chk("fp64_infx0_nan", {last.nan, last.inf}, 2'b10);
    send(2'b10, 64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    drain();
    chk("fp64_inf", {last.nan, last.inf}, 2'b01);
    chk("fp64_exp_max", last.exp_max, 13'd3070);
    // back-pressure: both stages fill, outputs held, then drain in order
    i_ready = 0;
    n0 = nout;
    send(2'b00, 64'h3C01_3C02_3C03_3C04, 64'h4400_4800_4C00_5000);
    send(2'b01, 64'h4000_0000_C040_0000, 64'h3F00_0000_4100_0000);
    i_valid = 1; i_mode_sel = 2'b00; i_a = 64'h0001_8001_7BFF_0400; i_b = 64'h3C00_BC00_3C00_0000;
    #1;
    chk("stall_ready", o_ready_in, 0);
    chk("stall_valid", o_valid, 1);
    snap = cap();
    for (int c = 0; c < 3; c++) begin
      cyc(acc);
      chk("stall_nacc", acc, 0);
      chk("stall_hold", cap(), snap);
    end
    i_ready = 1;
    n0 = n0 + 0;
    begin
      int n = 0;
      do begin cyc(acc); n++; end while (!acc && n < 20);
      chk("stall_acc", acc, 1);
    end
    drain();
    chk("stall_count", nout - n0, 3);
    // idle beat between two FP16 beats
    n0 = nout;
    send(2'b00, 64'h3C00_0000_3C00_0000, 64'h3C00_3C00_3C00_3C00);
    send(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    send(2'b00, 64'h4000_4000_4000_4000, 64'h4000_4000_4000_4000);
    drain();
    chk("idle_count", nout - n0, 2);
    chk("idle_mode", last.mode, 2'b00);
    // random traffic with random back-pressure
    acc = 0;
    for (int c = 0; c < 80; c++) begin
      if (!i_valid || acc) begin
        i_valid = $urandom_range(0, 3) != 0;
        i_mode_sel = 2'($urandom_range(0, 3));
        i_a = {$urandom, $urandom};
        i_b = {$urandom, $urandom};
        if ($urandom_range(0, 4) == 0) i_b = '0;
      end
      i_ready = $urandom_range(0, 3) != 0;
      cyc(acc);
    end
    i_ready = 1;
    drain();
    // reset with two beats in flight
    send(2'b00, 64'h3C00_3C00_3C00_3C00, 64'h3C00_3C00_3C00_3C00);
    send(2'b01, 64'h3F80_0000_3F80_0000, 64'h4000_0000_4000_0000);
    chk("inflight_valid", o_valid, 1);
    rstn = 0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_mode", o_mode_sel, 2'b11);
    chk("midrst_out", cap(), rx);
    sbv.delete();
    n0 = nout;
    @(posedge clk);
    #1;
    rstn = 1;
    repeat (5) cyc(acc);
    chk("midrst_no_stale", nout - n0, 0);
    chk("midrst_ready", o_ready_in, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
